data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 16 +
 rtl/data_mem_responder_array.sv | 43 ++++
 rtl/data_mem_responder.sv | 101 ++++++++++
 tb/tb_data_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM type and default sizing for the data memory responder.
// Latency counter is 4 bits wide, enough for the 1..15 latency range.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;
  localparam int LANES           = 4;

endpackage

// File: rtl/data_mem_responder_array.sv
// dmem_array: word storage with byte-enabled synchronous write and a
// registered read port whose output holds until the next read.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [LANES-1:0]         be_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  output logic [DataWidth-1:0]     rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory slave for the memory stage.
// One access in flight; completion is a registered one-cycle data_valid.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = DEFAULT_DEPTH,
  parameter int Latency   = DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 request,
  input  logic                 we_re,
  input  logic [3:0]           mask,
  input  logic [DataWidth-1:0] address,
  input  logic [DataWidth-1:0] store_data,
  output logic                 busy,
  output logic                 data_valid,
  output logic [DataWidth-1:0] load_data
);

  localparam int AW = $clog2(Depth);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(Latency - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 dv_q;
  logic                 we_q;
  logic [3:0]           mask_q;
  logic [AW-1:0]        idx_q;
  logic [DataWidth-1:0] wdata_q;

  logic arr_we;
  logic arr_re;
  logic unused_addr;

  assign unused_addr = ^{address[DataWidth-1:AW+2], address[1:0]};

  // WAIT leaves when the counter reaches zero, so RESP lands on
  // edge t+Latency-1 and the registered pulse follows edge t+Latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (request) begin
            we_q    <= we_re;
            mask_q  <= mask;
            idx_q   <= address[AW+1:2];
            wdata_q <= store_data;
            cnt_q   <= LAT_M1;
            state_q <= (Latency == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          dv_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign arr_we = (state_q == ST_RESP) && we_q;
  assign arr_re = (state_q == ST_RESP) && !we_q;

  dmem_array #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .be_i    (mask_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (load_data)
  );

  assign busy       = (state_q != ST_IDLE);
  assign data_valid = dv_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (latency 2 and 1) checked each
// cycle against a countdown/array model, plus directed literal checks.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req  [2];
  logic        wer  [2];
  logic [3:0]  msk  [2];
  logic [31:0] adr  [2];
  logic [31:0] sdat [2];
  logic        bsy  [2];
  logic        dv   [2];
  logic [31:0] ld   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DataWidth(32), .Depth(256), .Latency(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .request(req[0]), .we_re(wer[0]),
    .mask(msk[0]), .address(adr[0]), .store_data(sdat[0]),
    .busy(bsy[0]), .data_valid(dv[0]), .load_data(ld[0])
  );

  data_mem_responder #(.DataWidth(32), .Depth(256), .Latency(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .request(req[1]), .we_re(wer[1]),
    .mask(msk[1]), .address(adr[1]), .store_data(sdat[1]),
    .busy(bsy[1]), .data_valid(dv[1]), .load_data(ld[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: an accepted access completes exactly lat cycles later.
  int          lat_of [2] = '{2, 1};
  int          rem    [2] = '{0, 0};
  logic        p_we   [2];
  logic [3:0]  p_msk  [2];
  logic [31:0] p_adr  [2];
  logic [31:0] p_dat  [2];
  logic [31:0] mmem   [2][256];
  bit          kn     [2][256];
  logic        e_dv   [2] = '{1'b0, 1'b0};
  logic [31:0] e_ld   [2] = '{32'h0, 32'h0};
  bit          e_ldk  [2] = '{1'b1, 1'b1};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem[k]   = 0;
        e_dv[k]  = 1'b0;
        e_ld[k]  = 32'h0;
        e_ldk[k] = 1'b1;
      end else begin
        e_dv[k] = 1'b0;
        if (rem[k] > 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            int w;
            w = (p_adr[k] / 4) % 256;
            e_dv[k] = 1'b1;
            if (p_we[k]) begin
              for (int b = 0; b < 4; b++)
                if (p_msk[k][b]) mmem[k][w][8*b +: 8] = p_dat[k][8*b +: 8];
              if (p_msk[k] == 4'hF) kn[k][w] = 1'b1;
            end else begin
              e_ld[k]  = mmem[k][w];
              e_ldk[k] = kn[k][w];
            end
          end
        end else if (req[k]) begin
          p_we[k]  = wer[k];
          p_msk[k] = msk[k];
          p_adr[k] = adr[k];
          p_dat[k] = sdat[k];
          rem[k]   = lat_of[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d.busy", k), {31'b0, bsy[k]}, {31'b0, rem[k] > 0});
      chk($sformatf("dut%0d.data_valid", k), {31'b0, dv[k]}, {31'b0, e_dv[k]});
      if (e_ldk[k])
        chk($sformatf("dut%0d.load_data", k), ld[k], e_ld[k]);
    end
  end

  task automatic access(input int k, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    req[k] = 1'b1; wer[k] = w; msk[k] = m; adr[k] = a; sdat[k] = d;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    req[k] = 1'b0;
    while (!dv[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      failures++;
      $display("FAIL dut%0d.timeout actual=no_data_valid required=data_valid", k);
    end
    rd = ld[k];
  endtask

  logic [31:0] rd;
  int          lat;
  int          cnt;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wer[k] = 1'b0; msk[k] = 4'h0;
      adr[k] = 32'h0; sdat[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk("reset.load_data", ld[0], 32'h0);
    chk("reset.busy", {31'b0, bsy[0]}, 32'h0);
    rst_n = 1'b1;

    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
    chk("store.latency", lat, 2);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat);
    chk("load.latency", lat, 2);
    chk("load.full_word", rd, 32'hDEADBEEF);

    access(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, rd, lat);
    chk("store_mask.keeps_load_data", rd, 32'hDEADBEEF);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat);
    chk("load.byte_merge", rd, 32'hDEADBEAA);

    access(0, 1'b0, 4'h0, 32'h413, 32'h0, rd, lat);
    chk("load.wrap", rd, 32'hDEADBEAA);

    access(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, rd, lat);
    chk("store_mask0.latency", lat, 2);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat);
    chk("load.mask0_no_write", rd, 32'hDEADBEAA);

    // Request re-raised while busy must be dropped.
    access(0, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D, rd, lat);
    @(negedge clk);
    req[0] = 1'b1; wer[0] = 1'b1; msk[0] = 4'hF;
    adr[0] = 32'h30; sdat[0] = 32'h0BADC0DE;
    @(posedge clk);
    @(negedge clk);
    adr[0] = 32'h44; sdat[0] = 32'h99999999;
    @(negedge clk);
    req[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dv[0]) cnt++;
    end
    chk("busy_req.one_pulse", cnt, 1);
    access(0, 1'b0, 4'h0, 32'h44, 32'h0, rd, lat);
    chk("busy_req.no_write", rd, 32'hCAFEF00D);
    access(0, 1'b0, 4'h0, 32'h30, 32'h0, rd, lat);
    chk("busy_req.accepted_write", rd, 32'h0BADC0DE);

    // Reset in WAIT aborts the store.
    access(0, 1'b1, 4'hF, 32'h20, 32'h11112222, rd, lat);
    @(negedge clk);
    req[0] = 1'b1; wer[0] = 1'b1; msk[0] = 4'hF;
    adr[0] = 32'h20; sdat[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2 rst_n = 1'b0;
    cnt = 0;
    @(negedge clk);
    if (dv[0]) cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dv[0]) cnt++;
    end
    chk("reset_abort.no_pulse", cnt, 0);
    chk("reset_abort.load_data_cleared", ld[0], 32'h0);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat);
    chk("reset_abort.prior_contents", rd, 32'h11112222);

    // Latency 1: held request gives a pulse every second cycle.
    access(1, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, rd, lat);
    chk("lat1.latency", lat, 1);
    @(negedge clk);
    req[1] = 1'b1; wer[1] = 1'b0; msk[1] = 4'h0; adr[1] = 32'h0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("lat1.pulse%0d", i), {31'b0, dv[1]}, {31'b0, i % 2 == 1});
      if (dv[1]) cnt++;
    end
    req[1] = 1'b0;
    chk("lat1.pulse_count", cnt, 5);
    chk("lat1.load_data", ld[1], 32'hA5A5A5A5);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
